// File: rtl/numa_udp_hdr_tx.sv
// Ethernet/IPv4/UDP transmit header generator: snapshots the PIO address registers on start,
// folds the IPv4 header checksum, then streams the 42 header bytes one per valid/ready beat.
module numa_udp_hdr_tx #(
    parameter logic [15:0] UDP_SRC_PORT = 16'd3422,
    parameter logic [15:0] UDP_DST_PORT = 16'd3422,
    parameter logic [7:0]  IP_TTL       = 8'd64,
    parameter logic [15:0] MAX_PAYLOAD  = 16'd1472
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_v4addr,
    input  logic [47:0] if_macaddr,
    input  logic [31:0] dest_v4addr,
    input  logic [47:0] dest_macaddr,
    input  logic        start,
    input  logic [15:0] payload_len,
    output logic        busy,
    output logic        err,
    output logic [7:0]  hdr_data,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic        hdr_last,
    output logic        done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUM  = 2'd1;
    localparam logic [1:0] FOLD = 2'd2;
    localparam logic [1:0] SEND = 2'd3;

    localparam logic [3:0] LAST_WORD = 4'd9;
    localparam logic [5:0] LAST_BYTE = 6'd41;

    logic [1:0]  state;
    logic [47:0] dmac_q;
    logic [47:0] smac_q;
    logic [31:0] sip_q;
    logic [31:0] dip_q;
    logic [15:0] plen_q;
    logic [15:0] ip_id;
    logic [19:0] acc;
    logic [15:0] csum;
    logic [3:0]  word_idx;
    logic [5:0]  byte_idx;
    logic        done_q;
    logic        err_q;

    logic [15:0] total_len;
    logic [15:0] udp_len;
    logic [15:0] sum_word;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic [7:0]  tx_byte;

    assign total_len = plen_q + 16'd28;
    assign udp_len   = plen_q + 16'd8;

    // IPv4 header words in wire order; the checksum slot contributes zero.
    always_comb begin
        sum_word = 16'h0000;
        case (word_idx)
            4'd0:    sum_word = 16'h4500;
            4'd1:    sum_word = total_len;
            4'd2:    sum_word = ip_id;
            4'd3:    sum_word = 16'h4000;
            4'd4:    sum_word = {IP_TTL, 8'h11};
            4'd5:    sum_word = 16'h0000;
            4'd6:    sum_word = sip_q[31:16];
            4'd7:    sum_word = sip_q[15:0];
            4'd8:    sum_word = dip_q[31:16];
            4'd9:    sum_word = dip_q[15:0];
            default: sum_word = 16'h0000;
        endcase
    end

    // Ten 16-bit words carry at most 4 bits; two end-around folds always suffice.
    always_comb begin
        fold1 = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
        fold2 = fold1[15:0] + {15'd0, fold1[16]};
    end

    always_comb begin
        tx_byte = 8'h00;
        case (byte_idx)
            6'd0:    tx_byte = dmac_q[47:40];
            6'd1:    tx_byte = dmac_q[39:32];
            6'd2:    tx_byte = dmac_q[31:24];
            6'd3:    tx_byte = dmac_q[23:16];
            6'd4:    tx_byte = dmac_q[15:8];
            6'd5:    tx_byte = dmac_q[7:0];
            6'd6:    tx_byte = smac_q[47:40];
            6'd7:    tx_byte = smac_q[39:32];
            6'd8:    tx_byte = smac_q[31:24];
            6'd9:    tx_byte = smac_q[23:16];
            6'd10:   tx_byte = smac_q[15:8];
            6'd11:   tx_byte = smac_q[7:0];
            6'd12:   tx_byte = 8'h08;
            6'd13:   tx_byte = 8'h00;
            6'd14:   tx_byte = 8'h45;
            6'd15:   tx_byte = 8'h00;
            6'd16:   tx_byte = total_len[15:8];
            6'd17:   tx_byte = total_len[7:0];
            6'd18:   tx_byte = ip_id[15:8];
            6'd19:   tx_byte = ip_id[7:0];
            6'd20:   tx_byte = 8'h40;
            6'd21:   tx_byte = 8'h00;
            6'd22:   tx_byte = IP_TTL;
            6'd23:   tx_byte = 8'h11;
            6'd24:   tx_byte = csum[15:8];
            6'd25:   tx_byte = csum[7:0];
            6'd26:   tx_byte = sip_q[31:24];
            6'd27:   tx_byte = sip_q[23:16];
            6'd28:   tx_byte = sip_q[15:8];
            6'd29:   tx_byte = sip_q[7:0];
            6'd30:   tx_byte = dip_q[31:24];
            6'd31:   tx_byte = dip_q[23:16];
            6'd32:   tx_byte = dip_q[15:8];
            6'd33:   tx_byte = dip_q[7:0];
            6'd34:   tx_byte = UDP_SRC_PORT[15:8];
            6'd35:   tx_byte = UDP_SRC_PORT[7:0];
            6'd36:   tx_byte = UDP_DST_PORT[15:8];
            6'd37:   tx_byte = UDP_DST_PORT[7:0];
            6'd38:   tx_byte = udp_len[15:8];
            6'd39:   tx_byte = udp_len[7:0];
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dmac_q   <= 48'd0;
            smac_q   <= 48'd0;
            sip_q    <= 32'd0;
            dip_q    <= 32'd0;
            plen_q   <= 16'd0;
            ip_id    <= 16'd0;
            acc      <= 20'd0;
            csum     <= 16'd0;
            word_idx <= 4'd0;
            byte_idx <= 6'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (payload_len <= MAX_PAYLOAD) begin
                            dmac_q   <= dest_macaddr;
                            smac_q   <= if_macaddr;
                            sip_q    <= if_v4addr;
                            dip_q    <= dest_v4addr;
                            plen_q   <= payload_len;
                            acc      <= 20'd0;
                            word_idx <= 4'd0;
                            state    <= SUM;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SUM: begin
                    acc <= acc + {4'd0, sum_word};
                    if (word_idx == LAST_WORD) begin
                        state <= FOLD;
                    end else begin
                        word_idx <= word_idx + 4'd1;
                    end
                end
                FOLD: begin
                    csum     <= ~fold2;
                    byte_idx <= 6'd0;
                    state    <= SEND;
                end
                SEND: begin
                    if (hdr_ready) begin
                        if (byte_idx == LAST_BYTE) begin
                            done_q <= 1'b1;
                            ip_id  <= ip_id + 16'd1;
                            state  <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 6'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stream outputs decode straight from the state so reset drops them without a clock.
    assign busy      = (state != IDLE);
    assign hdr_valid = (state == SEND);
    assign hdr_last  = (state == SEND) && (byte_idx == LAST_BYTE);
    assign hdr_data  = (state == SEND) ? tx_byte : 8'h00;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_numa_udp_hdr_tx.sv
// Self-checking bench for numa_udp_hdr_tx: frames are compared byte-for-byte against a
// header builder that lays out the wire format and computes the ones-complement checksum.
module tb_numa_udp_hdr_tx;

    localparam logic [47:0] DEF_SMAC = 48'h003776000001;
    localparam logic [47:0] DEF_DMAC = 48'hffffffffffff;
    localparam logic [31:0] DEF_SIP  = 32'h0A0015C7;
    localparam logic [31:0] DEF_DIP  = 32'h0A0015FF;
    localparam logic [15:0] PORT     = 16'd3422;
    localparam logic [7:0]  TTL      = 8'd64;

    logic        clk;
    logic        rst;
    logic [31:0] if_v4addr;
    logic [47:0] if_macaddr;
    logic [31:0] dest_v4addr;
    logic [47:0] dest_macaddr;
    logic        start;
    logic [15:0] payload_len;
    logic        busy;
    logic        err;
    logic [7:0]  hdr_data;
    logic        hdr_valid;
    logic        hdr_ready;
    logic        hdr_last;
    logic        done;

    int tests_run;
    int tests_failed;

    logic [15:0] model_id;
    logic [7:0]  exp_bytes [42];
    logic [7:0]  cap_data  [42];
    int          cap_when  [42];
    int nbytes, last_at, done_at, busy_k1, busy_at_done;
    int stall_bad, last_bad, gap_bad, early_bad, err_seen, rst_valid;

    numa_udp_hdr_tx dut (
        .clk          (clk),
        .rst          (rst),
        .if_v4addr    (if_v4addr),
        .if_macaddr   (if_macaddr),
        .dest_v4addr  (dest_v4addr),
        .dest_macaddr (dest_macaddr),
        .start        (start),
        .payload_len  (payload_len),
        .busy         (busy),
        .err          (err),
        .hdr_data     (hdr_data),
        .hdr_valid    (hdr_valid),
        .hdr_ready    (hdr_ready),
        .hdr_last     (hdr_last),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference header: fields laid out in wire order, checksum over the 20 IP header bytes.
    task automatic model_frame(input logic [47:0] dmac, input logic [47:0] smac,
                               input logic [31:0] sip, input logic [31:0] dip,
                               input logic [15:0] plen, input logic [15:0] id);
        logic [7:0]  q[$];
        logic [15:0] tl;
        logic [15:0] ul;
        logic [15:0] cs;
        int unsigned sum;
        q  = {};
        tl = plen + 16'd28;
        ul = plen + 16'd8;
        for (int i = 5; i >= 0; i--) q.push_back(dmac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) q.push_back(smac[8*i +: 8]);
        q.push_back(8'h08); q.push_back(8'h00);
        q.push_back(8'h45); q.push_back(8'h00);
        q.push_back(tl[15:8]); q.push_back(tl[7:0]);
        q.push_back(id[15:8]); q.push_back(id[7:0]);
        q.push_back(8'h40); q.push_back(8'h00);
        q.push_back(TTL); q.push_back(8'h11);
        q.push_back(8'h00); q.push_back(8'h00);
        for (int i = 3; i >= 0; i--) q.push_back(sip[8*i +: 8]);
        for (int i = 3; i >= 0; i--) q.push_back(dip[8*i +: 8]);
        q.push_back(PORT[15:8]); q.push_back(PORT[7:0]);
        q.push_back(PORT[15:8]); q.push_back(PORT[7:0]);
        q.push_back(ul[15:8]); q.push_back(ul[7:0]);
        q.push_back(8'h00); q.push_back(8'h00);
        sum = 0;
        for (int i = 14; i < 34; i += 2) sum += {16'd0, q[i], q[i+1]};
        while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
        cs = ~sum[15:0];
        q[24] = cs[15:8];
        q[25] = cs[7:0];
        for (int i = 0; i < 42; i++) exp_bytes[i] = q[i];
    endtask

    task automatic apply_defaults();
        if_v4addr    = DEF_SIP;
        if_macaddr   = DEF_SMAC;
        dest_v4addr  = DEF_DIP;
        dest_macaddr = DEF_DMAC;
    endtask

    task automatic send_start(input logic [15:0] plen);
        start       = 1'b1;
        payload_len = plen;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called just after the start edge N; loop index k is the cycle relative to N.
    // hook: 1 change dest ip after byte 5, 2 reset at byte 20, 3 stray start at k=20.
    task automatic capture(input int ready_mode, input int hook, input logic [31:0] hook_addr,
                           input int chain, input logic [15:0] chain_len, input int budget);
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        nbytes = 0; last_at = -1; done_at = -1; busy_k1 = 0; busy_at_done = 1;
        stall_bad = 0; last_bad = 0; gap_bad = 0; early_bad = 0; err_seen = 0; rst_valid = 1;
        prev_stall = 1'b0; prev_data = 8'h00; prev_last = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            case (ready_mode)
                0:       hdr_ready = 1'b1;
                1:       hdr_ready = (k % 2 == 0);
                default: hdr_ready = ($urandom_range(0, 1) != 0);
            endcase
            if (hook == 3 && k == 20) begin
                start       = 1'b1;
                payload_len = 16'd100;
            end
            @(negedge clk);
            if (k == 1) busy_k1 = int'(busy);
            if (err) err_seen = 1;
            if (hdr_last && !(hdr_valid && nbytes == 41)) last_bad = 1;
            if (hdr_valid && k < 12) early_bad = 1;
            if (!hdr_valid && nbytes > 0 && nbytes < 42) gap_bad = 1;
            if (prev_stall && (!hdr_valid || hdr_data !== prev_data || hdr_last !== prev_last))
                stall_bad = 1;
            if (hook == 2 && hdr_valid && nbytes == 20) begin
                rst = 1'b1;
                #1;
                rst_valid = int'(hdr_valid);
                return;
            end
            if (hdr_last) last_at = k;
            if (done) begin
                done_at      = k;
                busy_at_done = int'(busy);
                if (chain != 0) begin
                    start       = 1'b1;
                    payload_len = chain_len;
                end
            end
            prev_stall = hdr_valid && !hdr_ready;
            prev_data  = hdr_data;
            prev_last  = hdr_last;
            if (hdr_valid && hdr_ready) begin
                if (nbytes < 42) begin
                    cap_data[nbytes] = hdr_data;
                    cap_when[nbytes] = k;
                    nbytes++;
                end else begin
                    last_bad = 1;
                end
            end
            if (hook == 1 && nbytes == 6) dest_v4addr = hook_addr;
            @(posedge clk); #1;
            start = 1'b0;
            if (done_at >= 0) return;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; hdr_ready = 1'b0; payload_len = 16'd0;
        apply_defaults();
        model_id = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        tests_run++; if (hdr_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", hdr_valid); end
        tests_run++; if (hdr_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_last: got %b expected 0", hdr_last); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        tests_run++; if (hdr_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_data: got %h expected 00", hdr_data); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_default_frame();
        apply_defaults();
        model_frame(DEF_DMAC, DEF_SMAC, DEF_SIP, DEF_DIP, 16'd64, model_id);
        send_start(16'd64);
        capture(0, 0, 32'd0, 0, 16'd0, 200);
        tests_run++; if (nbytes != 42) begin tests_failed++; $display("[TB] FAIL default_count: got %0d expected 42", nbytes); end
        for (int i = 0; i < 42; i++) begin
            tests_run++;
            if (cap_data[i] !== exp_bytes[i]) begin tests_failed++; $display("[TB] FAIL default_byte[%0d]: got %h expected %h", i, cap_data[i], exp_bytes[i]); end
        end
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (cap_data[i] !== 8'hff) begin tests_failed++; $display("[TB] FAIL default_dmac[%0d]: got %h expected ff", i, cap_data[i]); end
        end
        tests_run++; if ({cap_data[16], cap_data[17]} !== 16'h005c) begin tests_failed++; $display("[TB] FAIL default_total_len: got %h%h expected 005c", cap_data[16], cap_data[17]); end
        tests_run++; if ({cap_data[24], cap_data[25]} !== 16'hFACB) begin tests_failed++; $display("[TB] FAIL default_csum: got %h%h expected facb", cap_data[24], cap_data[25]); end
        tests_run++; if ({cap_data[38], cap_data[39]} !== 16'h0048) begin tests_failed++; $display("[TB] FAIL default_udp_len: got %h%h expected 0048", cap_data[38], cap_data[39]); end
        for (int i = 0; i < 42; i++) begin
            tests_run++;
            if (cap_when[i] != 12 + i) begin tests_failed++; $display("[TB] FAIL default_timing[%0d]: got N+%0d expected N+%0d", i, cap_when[i], 12 + i); end
        end
        tests_run++; if (busy_k1 != 1) begin tests_failed++; $display("[TB] FAIL default_busy_n1: got %0d expected 1", busy_k1); end
        tests_run++; if (last_at != 53) begin tests_failed++; $display("[TB] FAIL default_last_at: got N+%0d expected N+53", last_at); end
        tests_run++; if (done_at != 54) begin tests_failed++; $display("[TB] FAIL default_done_at: got N+%0d expected N+54", done_at); end
        tests_run++; if (busy_at_done != 0) begin tests_failed++; $display("[TB] FAIL default_busy_at_done: got %0d expected 0", busy_at_done); end
        tests_run++; if (last_bad + early_bad + gap_bad + err_seen != 0) begin tests_failed++; $display("[TB] FAIL default_protocol: last %0d early %0d gap %0d err %0d expected all 0", last_bad, early_bad, gap_bad, err_seen); end
        @(negedge clk);
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL default_done_width: got %b expected 0", done); end
        @(posedge clk); #1;
        model_id = model_id + 16'd1;
    endtask

    task automatic test_stall_toggle();
        apply_defaults();
        model_frame(DEF_DMAC, DEF_SMAC, DEF_SIP, DEF_DIP, 16'd64, model_id);
        send_start(16'd64);
        capture(1, 0, 32'd0, 0, 16'd0, 200);
        tests_run++; if (nbytes != 42) begin tests_failed++; $display("[TB] FAIL stall_count: got %0d expected 42", nbytes); end
        for (int i = 0; i < 42; i++) begin
            tests_run++;
            if (cap_data[i] !== exp_bytes[i]) begin tests_failed++; $display("[TB] FAIL stall_byte[%0d]: got %h expected %h", i, cap_data[i], exp_bytes[i]); end
        end
        tests_run++; if (stall_bad != 0) begin tests_failed++; $display("[TB] FAIL stall_hold: got %0d expected 0", stall_bad); end
        tests_run++; if (gap_bad + last_bad != 0) begin tests_failed++; $display("[TB] FAIL stall_protocol: gap %0d last %0d expected 0", gap_bad, last_bad); end
        tests_run++; if (done_at != 95) begin tests_failed++; $display("[TB] FAIL stall_done_at: got N+%0d expected N+95", done_at); end
        model_id = model_id + 16'd1;
    endtask

    task automatic test_back_to_back();
        int stray;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_id = 16'd0;
        apply_defaults();
        model_frame(DEF_DMAC, DEF_SMAC, DEF_SIP, DEF_DIP, 16'd64, model_id);
        send_start(16'd64);
        capture(0, 3, 32'd0, 1, 16'd64, 200);
        tests_run++; if (done_at != 54) begin tests_failed++; $display("[TB] FAIL b2b_first_done_at: got N+%0d expected N+54", done_at); end
        for (int i = 0; i < 42; i++) begin
            tests_run++;
            if (cap_data[i] !== exp_bytes[i]) begin tests_failed++; $display("[TB] FAIL b2b_first_byte[%0d]: got %h expected %h", i, cap_data[i], exp_bytes[i]); end
        end
        tests_run++; if (err_seen != 0) begin tests_failed++; $display("[TB] FAIL b2b_stray_err: got %0d expected 0", err_seen); end
        model_id = model_id + 16'd1;
        model_frame(DEF_DMAC, DEF_SMAC, DEF_SIP, DEF_DIP, 16'd64, model_id);
        capture(0, 0, 32'd0, 0, 16'd0, 200);
        tests_run++; if (nbytes != 42) begin tests_failed++; $display("[TB] FAIL b2b_second_count: got %0d expected 42", nbytes); end
        for (int i = 0; i < 42; i++) begin
            tests_run++;
            if (cap_data[i] !== exp_bytes[i]) begin tests_failed++; $display("[TB] FAIL b2b_second_byte[%0d]: got %h expected %h", i, cap_data[i], exp_bytes[i]); end
        end
        tests_run++; if ({cap_data[18], cap_data[19]} !== 16'h0001) begin tests_failed++; $display("[TB] FAIL b2b_ip_id: got %h%h expected 0001", cap_data[18], cap_data[19]); end
        tests_run++; if ({cap_data[24], cap_data[25]} !== 16'hFACA) begin tests_failed++; $display("[TB] FAIL b2b_csum: got %h%h expected faca", cap_data[24], cap_data[25]); end
        tests_run++; if (done_at != 54) begin tests_failed++; $display("[TB] FAIL b2b_second_done_at: got N+%0d expected N+54", done_at); end
        stray = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (busy || hdr_valid) stray = 1;
        end
        @(posedge clk); #1;
        tests_run++; if (stray != 0) begin tests_failed++; $display("[TB] FAIL b2b_no_queue: got activity %0d expected 0", stray); end
        model_id = model_id + 16'd1;
    endtask

    task automatic test_length_limit();
        int active;
        apply_defaults();
        send_start(16'd1473);
        @(negedge clk);
        tests_run++; if (err !== 1'b1) begin tests_failed++; $display("[TB] FAIL len_err_pulse: got %b expected 1", err); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL len_busy: got %b expected 0", busy); end
        @(negedge clk);
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL len_err_width: got %b expected 0", err); end
        active = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (hdr_valid || busy) active = 1;
        end
        @(posedge clk); #1;
        tests_run++; if (active != 0) begin tests_failed++; $display("[TB] FAIL len_no_frame: got activity %0d expected 0", active); end
        model_frame(DEF_DMAC, DEF_SMAC, DEF_SIP, DEF_DIP, 16'd1472, model_id);
        send_start(16'd1472);
        capture(0, 0, 32'd0, 0, 16'd0, 200);
        tests_run++; if ({cap_data[16], cap_data[17]} !== 16'h05DC) begin tests_failed++; $display("[TB] FAIL len_max_total_len: got %h%h expected 05dc", cap_data[16], cap_data[17]); end
        for (int i = 0; i < 42; i++) begin
            tests_run++;
            if (cap_data[i] !== exp_bytes[i]) begin tests_failed++; $display("[TB] FAIL len_max_byte[%0d]: got %h expected %h", i, cap_data[i], exp_bytes[i]); end
        end
        tests_run++; if (done_at != 54 || err_seen != 0) begin tests_failed++; $display("[TB] FAIL len_max_done: done N+%0d err %0d expected N+54 and 0", done_at, err_seen); end
        model_id = model_id + 16'd1;
    endtask

    task automatic test_addr_change();
        apply_defaults();
        model_frame(DEF_DMAC, DEF_SMAC, DEF_SIP, DEF_DIP, 16'd64, model_id);
        send_start(16'd64);
        capture(0, 1, 32'h0A001501, 0, 16'd0, 200);
        tests_run++; if ({cap_data[30], cap_data[31], cap_data[32], cap_data[33]} !== 32'h0A0015FF) begin
            tests_failed++;
            $display("[TB] FAIL snap_dst_ip: got %h%h%h%h expected 0a0015ff", cap_data[30], cap_data[31], cap_data[32], cap_data[33]);
        end
        for (int i = 0; i < 42; i++) begin
            tests_run++;
            if (cap_data[i] !== exp_bytes[i]) begin tests_failed++; $display("[TB] FAIL snap_byte[%0d]: got %h expected %h", i, cap_data[i], exp_bytes[i]); end
        end
        tests_run++; if (done_at != 54) begin tests_failed++; $display("[TB] FAIL snap_done_at: got N+%0d expected N+54", done_at); end
        model_id = model_id + 16'd1;
        apply_defaults();
    endtask

    task automatic test_reset_mid_frame();
        int active;
        apply_defaults();
        send_start(16'd64);
        capture(0, 2, 32'd0, 0, 16'd0, 200);
        tests_run++; if (rst_valid != 0) begin tests_failed++; $display("[TB] FAIL rst_valid_drop: got %0d expected 0", rst_valid); end
        tests_run++; if (hdr_data !== 8'h00 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_outputs: data %h busy %b expected 00 and 0", hdr_data, busy); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        active = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done || hdr_valid || busy) active = 1;
        end
        @(posedge clk); #1;
        tests_run++; if (active != 0) begin tests_failed++; $display("[TB] FAIL rst_no_done: got activity %0d expected 0", active); end
        model_id = 16'd0;
        model_frame(DEF_DMAC, DEF_SMAC, DEF_SIP, DEF_DIP, 16'd64, model_id);
        send_start(16'd64);
        capture(0, 0, 32'd0, 0, 16'd0, 200);
        tests_run++; if ({cap_data[18], cap_data[19]} !== 16'h0000) begin tests_failed++; $display("[TB] FAIL rst_ip_id: got %h%h expected 0000", cap_data[18], cap_data[19]); end
        for (int i = 0; i < 42; i++) begin
            tests_run++;
            if (cap_data[i] !== exp_bytes[i]) begin tests_failed++; $display("[TB] FAIL rst_byte[%0d]: got %h expected %h", i, cap_data[i], exp_bytes[i]); end
        end
        tests_run++; if (done_at != 54) begin tests_failed++; $display("[TB] FAIL rst_done_at: got N+%0d expected N+54", done_at); end
        model_id = model_id + 16'd1;
    endtask

    task automatic test_random();
        logic [15:0] plen;
        for (int it = 0; it < 10; it++) begin
            if_v4addr    = $urandom;
            dest_v4addr  = $urandom;
            if_macaddr   = 48'({$urandom, $urandom});
            dest_macaddr = 48'({$urandom, $urandom});
            plen = (it == 3) ? 16'd1600 : 16'($urandom_range(0, 1472));
            if (plen > 16'd1472) begin
                send_start(plen);
                @(negedge clk);
                tests_run++; if (err !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rand_err[%0d]: err %b busy %b expected 1 and 0", it, err, busy); end
                @(posedge clk); #1;
            end else begin
                model_frame(dest_macaddr, if_macaddr, if_v4addr, dest_v4addr, plen, model_id);
                send_start(plen);
                capture(2, 0, 32'd0, 0, 16'd0, 400);
                tests_run++; if (nbytes != 42 || done_at < 0) begin tests_failed++; $display("[TB] FAIL rand_complete[%0d]: bytes %0d done N+%0d expected 42 and done", it, nbytes, done_at); end
                for (int i = 0; i < 42; i++) begin
                    tests_run++;
                    if (cap_data[i] !== exp_bytes[i]) begin tests_failed++; $display("[TB] FAIL rand_byte[%0d][%0d]: got %h expected %h", it, i, cap_data[i], exp_bytes[i]); end
                end
                tests_run++; if (stall_bad + gap_bad + last_bad + early_bad + err_seen != 0 || busy_at_done != 0) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_protocol[%0d]: stall %0d gap %0d last %0d early %0d err %0d busy %0d expected all 0",
                             it, stall_bad, gap_bad, last_bad, early_bad, err_seen, busy_at_done);
                end
                model_id = model_id + 16'd1;
            end
        end
        apply_defaults();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_default_frame();
        test_stall_toggle();
        test_back_to_back();
        test_length_limit();
        test_addr_change();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/numa_udp_hdr_tx.md
# numa_udp_hdr_tx

Transmit-side header generator that consumes the PCIe user registers (`if_v4addr`, `if_macaddr`, `dest_v4addr`, `dest_macaddr`) driven by the PIO register block. On a `start` pulse it snapshots those addresses and computes the IPv4 header checksum. It then streams a 42-byte Ethernet/IPv4/UDP header, one byte per beat, to the MAC TX path with valid/ready flow control. Payload bytes are appended downstream by the TX mux after `hdr_last`.

## Interface
- `UDP_SRC_PORT`, default 16'd3422: UDP source port.
- `UDP_DST_PORT`, default 16'd3422: UDP destination port.
- `IP_TTL`, default 8'd64: IPv4 TTL.
- `MAX_PAYLOAD`, default 16'd1472: largest accepted UDP payload length.

One clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock (PCIe user clock).
- `rst`  in  1  asynchronous active-high reset.
- `if_v4addr`  in  32  local IPv4 address.
- `if_macaddr`  in  48  local MAC address.
- `dest_v4addr`  in  32  destination IPv4 address.
- `dest_macaddr`  in  48  destination MAC address.
- `start`  in  1  single-cycle request to emit one header.
- `payload_len`  in  16  UDP payload bytes; sampled with `start`.
- `busy`  out  1  high from accepted start until done.
- `err`  out  1  one-cycle pulse when a start is rejected for length.
- `hdr_data`  out  8  header byte.
- `hdr_valid`  out  1  `hdr_data` valid.
- `hdr_ready`  in  1  sink accepts the byte.
- `hdr_last`  out  1  marks byte 41.
- `done`  out  1  one-cycle pulse after byte 41 is accepted.

## Operation
- States: IDLE, SUM, FOLD, SEND.
- IDLE:
  - `start` with `payload_len` <= MAX_PAYLOAD snapshots all four address inputs and `payload_len`, sets `busy`, clears the accumulator, word index = 0, and moves to SUM.
  - `start` with `payload_len` > MAX_PAYLOAD pulses `err` the next cycle and stays in IDLE.
- SUM:
  - Adds one 16-bit word per cycle into a 20-bit accumulator, for 10 cycles.
  - Word order: 0x4500; total_len = payload_len+28; ip_id; 0x4000 (DF); {IP_TTL, 8'h11}; 0x0000; src[31:16]; src[15:0]; dst[31:16]; dst[15:0].
- FOLD: one cycle. s = acc[15:0]+acc[19:16]; s = s[15:0]+s[16]; csum = ~s[15:0]. Then go to SEND with byte index 0.
- SEND:
  - Byte order: dest_mac[47:0] MSB first (0-5); src mac (6-11); 0x08 0x00 (12-13); 0x45 0x00; total_len; ip_id; 0x40 0x00; IP_TTL; 0x11; csum; src ip (26-29); dst ip (30-33); UDP_SRC_PORT; UDP_DST_PORT; udp_len = payload_len+8; 0x00 0x00 (UDP checksum unused, 40-41).
  - All 16-bit fields are sent MSB first.
  - The byte index advances only on `hdr_valid && hdr_ready`.
  - On acceptance of byte 41: `done` pulses, `ip_id` increments (16-bit, wraps 0xFFFF→0x0000), `busy` falls, and the state returns to IDLE.
- Address inputs changing while busy have no effect on the frame in flight; the snapshot is used.
- `start` while busy is ignored: no error and no queuing.

## Timing
- Reset values:
  - outputs: `busy`=0, `err`=0, `hdr_valid`=0, `hdr_last`=0, `done`=0, `hdr_data`=0.
  - internal: `ip_id`=0, state IDLE.
- Reset asserted mid-frame: `hdr_valid` deasserts asynchronously; no `done` is issued.
- Start accepted at edge N:
  - `busy`=1 from N+1.
  - SUM covers N+1..N+10; FOLD is N+11.
  - First `hdr_valid` at N+12.
- With `hdr_ready` held high, byte k is presented at N+12+k, and `hdr_last` at N+53.
- `done` and `busy`=0 occur at N+54. The earliest next start is accepted at N+54.
- While `hdr_valid && !hdr_ready`, `hdr_data` and `hdr_last` hold stable.
- `hdr_valid` never drops inside a frame until byte 41 is accepted.
- `hdr_last` is high only together with `hdr_valid` on byte 41.
- `err` appears at N+1 and `busy` stays 0.

## Test plan
- Defaults (if 10.0.21.199, dest 10.0.21.255, MACs 00:37:76:00:00:01 / ff:ff:ff:ff:ff:ff), payload_len=64, ready=1 -> bytes 0-5 = ff, bytes 16-17 = 00 5c, bytes 24-25 = FA CB, bytes 38-39 = 00 48; `hdr_last` at N+53, `done` at N+54.
- Same frame with `hdr_ready` toggled 1-0 every cycle -> identical 42-byte sequence, data stable during stalls, `done` at N+95.
- Two back-to-back frames -> second frame bytes 18-19 = 00 01 and checksum 0xFACA; `start` pulsed during the first frame is ignored.
- payload_len=1473 -> `err` pulse at N+1, no `hdr_valid`, `busy`=0; payload_len=1472 -> total_len 0x05DC.
- Change `dest_v4addr` to 10.0.21.1 at byte 5 -> frame still carries 0a 00 15 ff at bytes 30-33.
- Assert `rst` at byte 20 -> `hdr_valid`=0 immediately, no `done`; next frame starts with ip_id 00 00.
